// File: rtl/conv3d_host.sv
// Host-side sequencer for a serial 3-D convolver: buffers one input frame and streams it out.
// It then waits for completion and captures the serial results into a readable result buffer.
module conv3d_host #(
   parameter int N_IN    = 108,
   parameter int N_OUT   = 48,
   parameter int TIMEOUT = 1024
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               go,
   input  logic               wr_en,
   input  logic [6:0]         wr_addr,
   input  logic signed [7:0]  wr_data,
   input  logic [5:0]         rd_addr,
   output logic signed [19:0] rd_data,
   output logic               busy,
   output logic               done,
   output logic               timeout_err,
   output logic               CONV_start,
   output logic signed [7:0]  CONV_iData,
   input  logic               CONV_finish,
   input  logic signed [19:0] CONV_oData
);

   localparam int CNT_LIM = (TIMEOUT > N_IN) ? ((TIMEOUT > N_OUT) ? TIMEOUT : N_OUT)
                                             : ((N_IN > N_OUT) ? N_IN : N_OUT);
   localparam int CNT_W   = $clog2(CNT_LIM + 1);
   localparam int IN_AW   = $clog2(N_IN);
   localparam int OUT_AW  = $clog2(N_OUT);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SEND,
      S_WAIT,
      S_SKIP,
      S_READ,
      S_DONE
   } state_t;

   state_t                    state_q, state_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d, cnt_nxt;
   logic                      conv_start_q, conv_start_d;
   logic signed [7:0]         conv_idata_q, conv_idata_d;
   logic                      timeout_err_q, timeout_err_d;
   logic signed [19:0]        rd_data_q, rd_data_d;
   logic                      res_we;

   logic signed [7:0]         in_buf_q  [N_IN];
   logic signed [7:0]         in_buf_d  [N_IN];
   logic signed [19:0]        res_buf_q [N_OUT];
   logic signed [19:0]        res_buf_d [N_OUT];

   assign cnt_nxt = cnt_q + CNT_W'(1);

   // Samples are registered one cycle ahead so sample n appears in the same cycle as the n-th start strobe.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      conv_start_d  = 1'b0;
      conv_idata_d  = '0;
      timeout_err_d = timeout_err_q;
      res_we        = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (go) begin
               state_d       = S_SEND;
               cnt_d         = '0;
               conv_start_d  = 1'b1;
               conv_idata_d  = in_buf_q[0];
               timeout_err_d = 1'b0;
            end
         end
         S_SEND: begin
            if (cnt_q == CNT_W'(N_IN - 1)) begin
               state_d = S_WAIT;
               cnt_d   = '0;
            end else begin
               cnt_d        = cnt_nxt;
               conv_start_d = 1'b1;
               conv_idata_d = in_buf_q[cnt_nxt[IN_AW-1:0]];
            end
         end
         S_WAIT: begin
            if (CONV_finish) begin
               state_d = S_SKIP;
               cnt_d   = '0;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               state_d       = S_DONE;
               cnt_d         = '0;
               timeout_err_d = 1'b1;
            end else begin
               cnt_d = cnt_nxt;
            end
         end
         S_SKIP: begin
            state_d = S_READ;
            cnt_d   = '0;
         end
         S_READ: begin
            res_we = 1'b1;
            if (cnt_q == CNT_W'(N_OUT - 1)) begin
               state_d = S_DONE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_nxt;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      in_buf_d = in_buf_q;
      if (wr_en && (state_q == S_IDLE) && (int'(wr_addr) < N_IN)) begin
         in_buf_d[wr_addr] = wr_data;
      end
   end

   always_comb begin
      res_buf_d = res_buf_q;
      if (res_we) begin
         res_buf_d[cnt_q[OUT_AW-1:0]] = CONV_oData;
      end
   end

   always_comb begin
      rd_data_d = '0;
      if (int'(rd_addr) < N_OUT) begin
         rd_data_d = res_buf_q[rd_addr];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         conv_start_q  <= 1'b0;
         conv_idata_q  <= '0;
         timeout_err_q <= 1'b0;
         rd_data_q     <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         conv_start_q  <= conv_start_d;
         conv_idata_q  <= conv_idata_d;
         timeout_err_q <= timeout_err_d;
         rd_data_q     <= rd_data_d;
      end
   end

   // Buffer contents deliberately survive reset.
   always_ff @(posedge clk) begin
      in_buf_q  <= in_buf_d;
      res_buf_q <= res_buf_d;
   end

   assign busy        = (state_q != S_IDLE);
   assign done        = (state_q == S_DONE);
   assign timeout_err = timeout_err_q;
   assign CONV_start  = conv_start_q;
   assign CONV_iData  = conv_idata_q;
   assign rd_data     = rd_data_q;

endmodule

// File: tb/tb_conv3d_host.sv
// Self-checking bench for conv3d_host: serial convolver model, sample/result scoreboards,
// table-driven result reads and hand-written timeout / abort / busy-write sequences.
module tb_conv3d_host;

   localparam int N_IN    = 108;
   localparam int N_OUT   = 48;
   localparam int TIMEOUT = 1024;

   logic               clk = 1'b0;
   logic               reset;
   logic               go;
   logic               wr_en;
   logic [6:0]         wr_addr;
   logic signed [7:0]  wr_data;
   logic [5:0]         rd_addr;
   logic signed [19:0] rd_data;
   logic               busy;
   logic               done;
   logic               timeout_err;
   logic               CONV_start;
   logic signed [7:0]  CONV_iData;
   logic               CONV_finish;
   logic signed [19:0] CONV_oData;

   always #5 clk = ~clk;

   conv3d_host #(.N_IN(N_IN), .N_OUT(N_OUT), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .go(go), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy),
      .done(done), .timeout_err(timeout_err), .CONV_start(CONV_start),
      .CONV_iData(CONV_iData), .CONV_finish(CONV_finish), .CONV_oData(CONV_oData)
   );

   typedef struct {
      logic [5:0]         addr;
      logic signed [19:0] exp;
   } rd_vec_t;

   int                 checks = 0;
   int                 errors = 0;
   logic signed [7:0]  exp_q[$];
   logic signed [19:0] rd_q[$];
   logic signed [7:0]  in_model [N_IN];
   logic signed [19:0] vals [N_OUT];
   bit                 model_en;
   bit                 prev_start;
   int                 ev;
   int                 send_cnt;
   int                 done_cnt;

   task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // One clock: sample at the falling edge, score outputs, advance the convolver model.
   task automatic cycle();
      @(negedge clk);
      if (rd_q.size() > 0) check("rd_data", rd_data, rd_q.pop_front());
      if (CONV_start === 1'b1) begin
         send_cnt++;
         ev = 0;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL conv_idata: got unexpected sample %0d expected none", CONV_iData);
         end else begin
            check("conv_idata", CONV_iData, exp_q.pop_front());
         end
      end else if (prev_start) begin
         ev = 1;
      end else if (ev > 0) begin
         ev++;
      end
      prev_start = (CONV_start === 1'b1);
      if (done === 1'b1) done_cnt++;
      CONV_finish = 1'b0;
      if (model_en && ev == 20) CONV_finish = 1'b1;
      if (model_en && ev >= 22 && ev < 22 + N_OUT) CONV_oData = vals[ev-22];
   endtask

   task automatic read_check(input logic [5:0] a, input logic signed [19:0] e);
      rd_addr = a;
      rd_q.push_back(e);
      cycle();
   endtask

   task automatic push_frame();
      for (int i = 0; i < N_IN; i++) exp_q.push_back(in_model[i]);
   endtask

   task automatic run_frame(input string tag, input bit disturb, output int wait_len);
      int  n;
      bit  seen_done;
      push_frame();
      send_cnt = 0;
      done_cnt = 0;
      wait_len = -1;
      go = 1'b1;
      cycle();
      go = 1'b0;
      check({tag, " busy_after_go"}, busy, 1);
      check({tag, " terr_cleared"}, timeout_err, 0);
      n = 0;
      seen_done = 1'b0;
      while (!seen_done && n < 3000) begin
         if (disturb && send_cnt == 2) begin
            wr_en = 1'b1; wr_addr = 7'd5; wr_data = 8'sh7f;
         end
         if (disturb && !CONV_start && busy && ev == 5) go = 1'b1;
         cycle();
         wr_en = 1'b0;
         go    = 1'b0;
         n++;
         if (done === 1'b1) begin
            seen_done = 1'b1;
            wait_len  = ev;
         end
      end
      check({tag, " done_seen"}, seen_done, 1);
      check({tag, " send_len"}, send_cnt, N_IN);
      check({tag, " samples_left"}, exp_q.size(), 0);
      cycle();
      check({tag, " done_width"}, done_cnt, 1);
      check({tag, " busy_after_done"}, busy, 0);
   endtask

   rd_vec_t f1_tbl [6];
   rd_vec_t f3_tbl [6];
   int      wl;
   int      n;

   initial begin
      reset = 1'b1; go = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
      CONV_finish = 1'b0; CONV_oData = '0; model_en = 1'b0; prev_start = 1'b0; ev = 0;
      send_cnt = 0; done_cnt = 0;

      f1_tbl[0] = '{6'd0,  20'sd1000};
      f1_tbl[1] = '{6'd47, 20'sd1047};
      f1_tbl[2] = '{6'd48, 20'sd0};
      f1_tbl[3] = '{6'd63, 20'sd0};
      f1_tbl[4] = '{6'd20, 20'sd1020};
      f1_tbl[5] = '{6'd1,  20'sd1001};
      f3_tbl[0] = '{6'd0,  20'h80000};
      f3_tbl[1] = '{6'd1,  20'h7FFFF};
      f3_tbl[2] = '{6'd47, 20'sd547};
      f3_tbl[3] = '{6'd48, 20'sd0};
      f3_tbl[4] = '{6'd1,  20'h7FFFF};
      f3_tbl[5] = '{6'd0,  20'h80000};

      repeat (3) cycle();
      check("rst busy", busy, 0);
      check("rst done", done, 0);
      check("rst timeout_err", timeout_err, 0);
      check("rst conv_start", CONV_start, 0);
      check("rst conv_idata", CONV_iData, 0);
      check("rst rd_data", rd_data, 0);
      reset = 1'b0;
      cycle();

      for (int i = 0; i < N_IN; i++) begin
         wr_en = 1'b1; wr_addr = 7'(i); wr_data = 8'(i % 128);
         in_model[i] = 8'(i % 128);
         cycle();
      end
      wr_en = 1'b1; wr_addr = 7'd120; wr_data = 8'sh33;
      cycle();
      wr_en = 1'b0;

      for (int m = 0; m < N_OUT; m++) vals[m] = 20'(1000 + m);
      model_en = 1'b1;
      run_frame("f1", 1'b0, wl);
      check("f1 done_latency", wl, 22 + N_OUT);
      for (int m = 0; m < N_OUT; m++) read_check(6'(m), 20'(1000 + m));
      foreach (f1_tbl[i]) read_check(f1_tbl[i].addr, f1_tbl[i].exp);
      cycle();

      for (int m = 0; m < N_OUT; m++) vals[m] = 20'(2000 + m);
      run_frame("f2", 1'b1, wl);
      send_cnt = 0;
      repeat (130) cycle();
      check("f2 no_second_frame", send_cnt, 0);
      check("f2 idle_busy", busy, 0);
      read_check(6'd0, 20'sd2000);
      read_check(6'd47, 20'sd2047);
      cycle();

      model_en = 1'b0;
      run_frame("to", 1'b0, wl);
      check("to wait_len", wl, TIMEOUT + 1);
      check("to timeout_err", timeout_err, 1);
      repeat (5) cycle();
      check("to sticky", timeout_err, 1);
      read_check(6'd0, 20'sd2000);
      read_check(6'd30, 20'sd2030);
      read_check(6'd47, 20'sd2047);
      cycle();

      vals[0] = 20'h80000;
      vals[1] = 20'h7FFFF;
      for (int m = 2; m < N_OUT; m++) vals[m] = 20'(500 + m);
      model_en = 1'b1;
      run_frame("f3", 1'b0, wl);
      foreach (f3_tbl[i]) read_check(f3_tbl[i].addr, f3_tbl[i].exp);
      cycle();

      model_en = 1'b0;
      push_frame();
      send_cnt = 0;
      go = 1'b1;
      cycle();
      go = 1'b0;
      n = 0;
      while (send_cnt < 51 && n < 200) begin
         cycle();
         n++;
      end
      check("abort reached_sample50", CONV_iData, 50);
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      check("abort conv_start", CONV_start, 0);
      check("abort busy", busy, 0);
      check("abort conv_idata", CONV_iData, 0);
      exp_q.delete();
      cycle();

      for (int m = 0; m < N_OUT; m++) vals[m] = 20'(3000 + m);
      model_en = 1'b1;
      run_frame("f4", 1'b0, wl);
      read_check(6'd0, 20'sd3000);
      read_check(6'd47, 20'sd3047);
      cycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
